// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, stall encoding, op bit orders and divider states
package ex_stage_pkg;
    localparam int ID_TO_EX_WD  = 180;
    localparam int EX_TO_MEM_WD = 151;
    localparam int EX_TO_RF_WD  = 39;
    localparam int HILO_WD      = 66;
    localparam int StallBus     = 6;
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;
    localparam int ALU_ADD = 11, ALU_SUB = 10, ALU_SLT = 9, ALU_SLTU = 8;
    localparam int ALU_AND = 7, ALU_NOR = 6, ALU_OR = 5, ALU_XOR = 4;
    localparam int ALU_SLL = 3, ALU_SRL = 2, ALU_SRA = 1, ALU_LUI = 0;
    localparam int MEM_LB = 7, MEM_LBU = 6, MEM_LH = 5, MEM_LHU = 4;
    localparam int MEM_LW = 3, MEM_SB = 2, MEM_SH = 1, MEM_SW = 0;
    localparam int HILO_DIV = 3, HILO_DIVU = 2, HILO_MULT = 1, HILO_MULTU = 0;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;
    // Decoded fields occupy the low bits of id_to_ex_bus; the bits above are reserved.
    typedef struct packed {
        logic [3:0]  hilo_op;
        logic [7:0]  mem_op;
        logic [11:0] alu_op;
        logic [31:0] pc;
        logic        data_ram_en;
        logic        data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] rt_data;
    } id_to_ex_t;
    localparam int ID_FIELDS_WD = $bits(id_to_ex_t);
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: pipeline buses, stall handshake and data-SRAM request of the EX stage
interface ex_stage_if;
    import ex_stage_pkg::*;
    logic [StallBus-1:0]     stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;
    logic                    stallreq_for_ex;
    modport master (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );
    modport slave (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_rf_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );
endinterface

// File: rtl/ex_stage_div_iter.sv
// div_iter: radix-2 restoring divider, one quotient bit per cycle, signs applied at the end
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int CW = $clog2(DIV_ITERS);
    div_state_e state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0] r, q, d, a_abs, b_abs;
    logic neg_q, neg_r;
    logic [32:0] tmp, diff;
    assign a_abs = (signed_op & a[31]) ? -a : a;
    assign b_abs = (signed_op & b[31]) ? -b : b;
    assign tmp   = {r, q[31]};
    assign diff  = tmp - {1'b0, d};
    assign quotient  = neg_q ? -q : q;
    assign remainder = neg_r ? -r : r;
    // next state and status flags
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            DIV_IDLE: if (start) state_n = DIV_RUN;
            DIV_RUN: begin
                busy = 1'b1;
                if (cnt == CW'(DIV_ITERS - 1)) state_n = DIV_DONE;
            end
            DIV_DONE: begin
                done = 1'b1;
                if (ack) state_n = DIV_IDLE;
            end
            default: state_n = DIV_IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= DIV_IDLE;
        else state <= state_n;
    end
    // operand latch on start, then one shift-subtract step per RUN cycle; a zero divisor leaves quotient all ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            r     <= '0;
            q     <= '0;
            d     <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            cnt   <= '0;
            r     <= '0;
            q     <= a_abs;
            d     <= b_abs;
            neg_q <= signed_op & (a[31] ^ b[31]) & (|b);
            neg_r <= signed_op & a[31];
        end else if (state == DIV_RUN) begin
            cnt <= cnt + 1'b1;
            r   <= diff[32] ? tmp[31:0] : diff[31:0];
            q   <= {q[30:0], ~diff[32]};
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: ID/EX register, ALU, mult/div and data-SRAM request of the execute stage
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input logic      clk,
    input logic      rst,
    ex_stage_if.master io
);
    id_to_ex_t ex_r;
    logic [31:0] a, b, ex_result, quotient, remainder;
    logic [4:0] sh;
    logic [11:0] op;
    logic [7:0] mem;
    logic [3:0] sel;
    logic [63:0] prod;
    logic [HILO_WD-1:0] hilo_bus;
    logic is_div, is_mult, sx, div_busy, div_done;
    logic is_byte, is_half, is_word;
    logic unused_bits;
    // bubble when ID stops but EX moves on, capture when ID moves, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst) ex_r <= '0;
        else if (io.stall[2] == Stop && io.stall[3] == NoStop) ex_r <= '0;
        else if (io.stall[2] == NoStop) ex_r <= io.id_to_ex_bus[ID_FIELDS_WD-1:0];
    end
    assign a   = ex_r.src_a;
    assign b   = ex_r.src_b;
    assign sh  = a[4:0];
    assign op  = ex_r.alu_op;
    assign mem = ex_r.mem_op;
    assign ex_result = ({32{op[ALU_ADD]}}  & (a + b))
                     | ({32{op[ALU_SUB]}}  & (a - b))
                     | ({32{op[ALU_SLT]}}  & {31'b0, $signed(a) < $signed(b)})
                     | ({32{op[ALU_SLTU]}} & {31'b0, a < b})
                     | ({32{op[ALU_AND]}}  & (a & b))
                     | ({32{op[ALU_NOR]}}  & ~(a | b))
                     | ({32{op[ALU_OR]}}   & (a | b))
                     | ({32{op[ALU_XOR]}}  & (a ^ b))
                     | ({32{op[ALU_SLL]}}  & (b << sh))
                     | ({32{op[ALU_SRL]}}  & (b >> sh))
                     | ({32{op[ALU_SRA]}}  & 32'($signed(b) >>> sh))
                     | ({32{op[ALU_LUI]}}  & {b[15:0], 16'b0});
    assign is_byte = mem[MEM_LB] | mem[MEM_LBU] | mem[MEM_SB];
    assign is_half = mem[MEM_LH] | mem[MEM_LHU] | mem[MEM_SH];
    assign is_word = mem[MEM_LW] | mem[MEM_SW];
    assign sel = is_byte ? 4'b0001 << ex_result[1:0]
               : is_half ? (ex_result[1] ? 4'b1100 : 4'b0011)
               : is_word ? 4'b1111 : 4'b0000;
    assign io.data_sram_en    = ex_r.data_ram_en & (io.stall[3] == NoStop);
    assign io.data_sram_wen   = (io.data_sram_en & ex_r.data_ram_wen) ? sel : 4'b0000;
    assign io.data_sram_addr  = ex_result;
    assign io.data_sram_wdata = mem[MEM_SB] ? {4{ex_r.rt_data[7:0]}}
                              : mem[MEM_SH] ? {2{ex_r.rt_data[15:0]}} : ex_r.rt_data;
    // one multiplier serves both forms: sign-extend to 64 bits only for mult
    assign sx      = ex_r.hilo_op[HILO_MULT];
    assign is_mult = ex_r.hilo_op[HILO_MULT] | ex_r.hilo_op[HILO_MULTU];
    assign is_div  = ex_r.hilo_op[HILO_DIV] | ex_r.hilo_op[HILO_DIVU];
    assign prod    = {{32{sx & a[31]}}, a} * {{32{sx & b[31]}}, b};
    div_iter #(.DIV_ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .signed_op (ex_r.hilo_op[HILO_DIV]),
        .a         (a),
        .b         (b),
        .ack       (io.stall[3] == NoStop),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );
    assign hilo_bus = is_mult ? {2'b11, prod}
                    : (is_div & div_done) ? {2'b11, remainder, quotient} : '0;
    assign io.stallreq_for_ex = (is_div & ~div_busy & ~div_done) | div_busy;
    assign io.ex_to_mem_bus = {mem, hilo_bus, ex_r.pc, ex_r.data_ram_en, ex_r.data_ram_wen, sel,
                               ex_r.sel_rf_res, ex_r.rf_we, ex_r.rf_waddr, ex_result};
    assign io.ex_to_rf_bus  = {ex_r.data_ram_en & ex_r.sel_rf_res, ex_r.rf_we, ex_r.rf_waddr, ex_result};
    assign unused_bits = ^{io.stall[5:4], io.stall[1:0], io.id_to_ex_bus[ID_TO_EX_WD-1:ID_FIELDS_WD]};
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: vector table, divider sequences and randomized model check for ex_stage
module tb_ex_stage;
    import ex_stage_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    ex_stage_if io();
    ex_stage #(.DIV_ITERS(32)) dut (.clk(clk), .rst(rst), .io(io));
    int tests = 0;
    int fails = 0;
    typedef struct {
        logic [3:0]  hilo;
        logic [7:0]  mem;
        logic [11:0] alu;
        logic [31:0] a, b, rt, res;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [65:0] hilo_exp;
        logic        ld;
    } vec_t;
    vec_t vecs[16];
    id_to_ex_t nop = '0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] oh(input int i);
        return 12'(1 << i);
    endfunction

    function automatic logic [ID_TO_EX_WD-1:0] pack(input id_to_ex_t f);
        return {19'($urandom), f};
    endfunction

    function automatic id_to_ex_t instr(input logic [3:0] hilo, input logic [7:0] mem,
                                        input logic [11:0] alu, input logic [31:0] a, b, rt);
        id_to_ex_t f;
        f.hilo_op = hilo;
        f.mem_op = mem;
        f.alu_op = alu;
        f.pc = $urandom;
        f.data_ram_en = |mem;
        f.data_ram_wen = |mem[2:0];
        f.sel_rf_res = |mem[7:3];
        f.rf_we = ~|mem[2:0];
        f.rf_waddr = 5'($urandom);
        f.src_a = a;
        f.src_b = b;
        f.rt_data = rt;
        return f;
    endfunction

    function automatic logic [31:0] alu_m(input logic [11:0] op, input logic [31:0] a, b);
        int s = int'(a[4:0]);
        if (op[ALU_ADD]) return a + b;
        if (op[ALU_SUB]) return a - b;
        if (op[ALU_SLT]) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (op[ALU_SLTU]) return (a < b) ? 32'd1 : 32'd0;
        if (op[ALU_AND]) return a & b;
        if (op[ALU_NOR]) return ~(a | b);
        if (op[ALU_OR]) return a | b;
        if (op[ALU_XOR]) return a ^ b;
        if (op[ALU_SLL]) return b << s;
        if (op[ALU_SRL]) return b >> s;
        if (op[ALU_SRA]) return 32'($signed(b) >>> s);
        if (op[ALU_LUI]) return b << 16;
        return 32'd0;
    endfunction

    function automatic logic [3:0] sel_m(input logic [7:0] mem, input logic [31:0] addr);
        if (mem[MEM_LB] | mem[MEM_LBU] | mem[MEM_SB]) return 4'(1 << addr[1:0]);
        if (mem[MEM_LH] | mem[MEM_LHU] | mem[MEM_SH]) return addr[1] ? 4'hC : 4'h3;
        if (mem[MEM_LW] | mem[MEM_SW]) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] wdata_m(input logic [7:0] mem, input logic [31:0] rt);
        if (mem[MEM_SB]) return {rt[7:0], rt[7:0], rt[7:0], rt[7:0]};
        if (mem[MEM_SH]) return {rt[15:0], rt[15:0]};
        return rt;
    endfunction

    function automatic logic [65:0] hilo_m(input logic [3:0] h, input logic [31:0] a, b);
        longint p;
        logic [63:0] u;
        if (h[HILO_MULT]) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {2'b11, 64'(p)};
        end
        if (h[HILO_MULTU]) begin
            u = {32'b0, a} * {32'b0, b};
            return {2'b11, u};
        end
        return 66'd0;
    endfunction

    task automatic div_m(input logic sgn, input logic [31:0] a, b, output logic [31:0] hi, lo);
        longint sa, sb;
        if (b == 0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    function automatic logic [EX_TO_MEM_WD-1:0] mem_bus_m(input id_to_ex_t r);
        logic [31:0] res = alu_m(r.alu_op, r.src_a, r.src_b);
        return {r.mem_op, hilo_m(r.hilo_op, r.src_a, r.src_b), r.pc, r.data_ram_en, r.data_ram_wen,
                sel_m(r.mem_op, res), r.sel_rf_res, r.rf_we, r.rf_waddr, res};
    endfunction

    task automatic run_div(input string name, input logic [31:0] hi, lo, input id_to_ex_t nxt);
        int n = 0;
        io.id_to_ex_bus = '0;
        while (io.stallreq_for_ex && n < 100) begin
            io.stall = 6'b001111;
            tick;
            n++;
        end
        chk({name, " stall cycles"}, 160'(n), 160'(33));
        chk({name, " hilo"}, 160'(io.ex_to_mem_bus[142:77]), 160'({2'b11, hi, lo}));
        io.stall = 6'b011111;
        tick;
        tick;
        chk({name, " hilo held"}, 160'(io.ex_to_mem_bus[142:77]), 160'({2'b11, hi, lo}));
        io.stall = 6'b000000;
        io.id_to_ex_bus = pack(nxt);
        tick;
        chk({name, " after hilo"}, 160'(io.ex_to_mem_bus[142:77]), 160'(0));
        chk({name, " after stallreq"}, 160'(io.stallreq_for_ex), 160'(nxt.hilo_op[HILO_DIV] | nxt.hilo_op[HILO_DIVU]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        id_to_ex_t f, mreg;
        logic [EX_TO_MEM_WD-1:0] eb;
        logic [31:0] hi, lo, da, db;
        logic [5:0] s;
        logic e;
        vecs[0]  = '{4'h0, 8'h01, oh(ALU_ADD), 32'h1000, 32'h4, 32'hDEADBEEF, 32'h1004, 1'b1, 4'hF, 32'hDEADBEEF, 66'd0, 1'b0};
        vecs[1]  = '{4'h0, 8'h04, oh(ALU_ADD), 32'h1000, 32'h3, 32'h12345678, 32'h1003, 1'b1, 4'h8, 32'h78787878, 66'd0, 1'b0};
        vecs[2]  = '{4'h0, 8'h02, oh(ALU_ADD), 32'h1000, 32'h2, 32'h12345678, 32'h1002, 1'b1, 4'hC, 32'h56785678, 66'd0, 1'b0};
        vecs[3]  = '{4'h0, 8'h08, oh(ALU_ADD), 32'h2000, 32'h8, 32'h0, 32'h2008, 1'b1, 4'h0, 32'h0, 66'd0, 1'b1};
        vecs[4]  = '{4'h0, 8'h40, oh(ALU_ADD), 32'h2000, 32'h1, 32'h0, 32'h2001, 1'b1, 4'h0, 32'h0, 66'd0, 1'b1};
        vecs[5]  = '{4'h2, 8'h00, 12'h0, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, {2'b11, 64'hFFFFFFFF_FFFFFFFE}, 1'b0};
        vecs[6]  = '{4'h1, 8'h00, 12'h0, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, {2'b11, 64'h00000001_FFFFFFFE}, 1'b0};
        vecs[7]  = '{4'h0, 8'h00, oh(ALU_SUB), 32'h5, 32'h7, 32'h0, 32'hFFFFFFFE, 1'b0, 4'h0, 32'h0, 66'd0, 1'b0};
        vecs[8]  = '{4'h0, 8'h00, oh(ALU_SLT), 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 1'b0, 4'h0, 32'h0, 66'd0, 1'b0};
        vecs[9]  = '{4'h0, 8'h00, oh(ALU_SLTU), 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 66'd0, 1'b0};
        vecs[10] = '{4'h0, 8'h00, oh(ALU_SRA), 32'h4, 32'h80000000, 32'h0, 32'hF8000000, 1'b0, 4'h0, 32'h0, 66'd0, 1'b0};
        vecs[11] = '{4'h0, 8'h00, oh(ALU_LUI), 32'h0, 32'h1234, 32'h0, 32'h12340000, 1'b0, 4'h0, 32'h0, 66'd0, 1'b0};
        vecs[12] = '{4'h0, 8'h00, oh(ALU_NOR), 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0, 32'h0000000F, 1'b0, 4'h0, 32'h0, 66'd0, 1'b0};
        vecs[13] = '{4'h0, 8'h00, oh(ALU_SLL), 32'h8, 32'h00FF00FF, 32'h0, 32'hFF00FF00, 1'b0, 4'h0, 32'h0, 66'd0, 1'b0};
        vecs[14] = '{4'h0, 8'h00, oh(ALU_SRL), 32'h8, 32'hFF000000, 32'h0, 32'h00FF0000, 1'b0, 4'h0, 32'h0, 66'd0, 1'b0};
        vecs[15] = '{4'h0, 8'h00, 12'h0, 32'h1, 32'h2, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 66'd0, 1'b0};
        // reset with a live instruction on the input
        io.stall = 6'b000000;
        io.id_to_ex_bus = pack(instr(4'h2, 8'h01, oh(ALU_ADD), 32'h10, 32'h20, 32'h30));
        tick;
        tick;
        chk("reset mem_bus", 160'(io.ex_to_mem_bus), 160'(0));
        chk("reset rf_bus", 160'(io.ex_to_rf_bus), 160'(0));
        chk("reset sram_en", 160'(io.data_sram_en), 160'(0));
        chk("reset stallreq", 160'(io.stallreq_for_ex), 160'(0));
        rst = 1'b1;
        // vector table
        foreach (vecs[i]) begin
            io.stall = 6'b000000;
            io.id_to_ex_bus = pack(instr(vecs[i].hilo, vecs[i].mem, vecs[i].alu, vecs[i].a, vecs[i].b, vecs[i].rt));
            tick;
            chk($sformatf("vec%0d result", i), 160'(io.ex_to_mem_bus[31:0]), 160'(vecs[i].res));
            chk($sformatf("vec%0d sram_en", i), 160'(io.data_sram_en), 160'(vecs[i].en));
            chk($sformatf("vec%0d sram_wen", i), 160'(io.data_sram_wen), 160'(vecs[i].wen));
            chk($sformatf("vec%0d sram_addr", i), 160'(io.data_sram_addr), 160'(vecs[i].res));
            chk($sformatf("vec%0d hilo", i), 160'(io.ex_to_mem_bus[142:77]), 160'(vecs[i].hilo_exp));
            chk($sformatf("vec%0d is_load", i), 160'(io.ex_to_rf_bus[38]), 160'(vecs[i].ld));
            if (|vecs[i].mem[2:0])
                chk($sformatf("vec%0d wdata", i), 160'(io.data_sram_wdata), 160'(vecs[i].wdata));
        end
        // divider: signed, unsigned, divide by zero, back-to-back
        io.id_to_ex_bus = pack(instr(4'h8, 8'h0, 12'h0, 32'hFFFFFFF9, 32'h2, 32'h0));
        tick;
        run_div("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, nop);
        io.id_to_ex_bus = pack(instr(4'h4, 8'h0, 12'h0, 32'hFFFFFFF9, 32'h2, 32'h0));
        tick;
        run_div("divu", 32'h1, 32'h7FFFFFFC, instr(4'h8, 8'h0, 12'h0, 32'h5, 32'h0, 32'h0));
        run_div("div 5/0", 32'h5, 32'hFFFFFFFF, instr(4'h8, 8'h0, 12'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0));
        run_div("div min/-1", 32'h0, 32'h80000000, nop);
        for (int i = 0; i < 8; i++) begin
            e = 1'($urandom_range(0, 1));
            da = $urandom;
            db = (i % 4 == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
            div_m(e, da, db, hi, lo);
            io.stall = 6'b000000;
            io.id_to_ex_bus = pack(instr(e ? 4'h8 : 4'h4, 8'h0, 12'h0, da, db, 32'h0));
            tick;
            run_div($sformatf("rdiv%0d", i), hi, lo, nop);
        end
        // reset during RUN
        io.stall = 6'b000000;
        io.id_to_ex_bus = pack(instr(4'h8, 8'h0, 12'h0, 32'h5, 32'h0, 32'h0));
        tick;
        io.stall = 6'b001111;
        for (int i = 0; i < 11; i++) tick;
        chk("mid-div stallreq", 160'(io.stallreq_for_ex), 160'(1));
        rst = 1'b0;
        tick;
        chk("reset div stallreq", 160'(io.stallreq_for_ex), 160'(0));
        chk("reset div bus", 160'(io.ex_to_mem_bus), 160'(0));
        rst = 1'b1;
        io.stall = 6'b000000;
        io.id_to_ex_bus = '0;
        tick;
        chk("post reset stallreq", 160'(io.stallreq_for_ex), 160'(0));
        // external hold, then bubble
        f = instr(4'h0, 8'h01, oh(ALU_ADD), 32'h3000, 32'h10, 32'hCAFEF00D);
        io.id_to_ex_bus = pack(f);
        tick;
        chk("hold pre sram_en", 160'(io.data_sram_en), 160'(1));
        io.stall = 6'b001111;
        io.id_to_ex_bus = pack(instr(4'h0, 8'h0, oh(ALU_OR), 32'h1, 32'h2, 32'h3));
        #1;
        chk("hold sram_en now", 160'(io.data_sram_en), 160'(0));
        tick;
        chk("hold mem_bus", 160'(io.ex_to_mem_bus), 160'(mem_bus_m(f)));
        chk("hold sram_wen", 160'(io.data_sram_wen), 160'(0));
        io.stall = 6'b000111;
        tick;
        chk("bubble mem_bus", 160'(io.ex_to_mem_bus), 160'(0));
        chk("bubble sram_en", 160'(io.data_sram_en), 160'(0));
        // randomized against the model register
        rst = 1'b0;
        tick;
        rst = 1'b1;
        mreg = '0;
        for (int i = 0; i < 300; i++) begin
            int k = $urandom_range(0, 12);
            int m = $urandom_range(0, 11);
            int h = $urandom_range(0, 3);
            int c = $urandom_range(0, 5);
            s = (c == 4) ? 6'b000111 : (c == 5) ? 6'b001111 : 6'b000000;
            f = instr(h == 2 ? 4'h2 : h == 3 ? 4'h1 : 4'h0, m < 8 ? 8'(1 << m) : 8'h0,
                      k == 12 ? 12'h0 : oh(k), $urandom, $urandom, $urandom);
            io.stall = s;
            io.id_to_ex_bus = pack(f);
            tick;
            if (s[2] && !s[3]) mreg = '0;
            else if (!s[2]) mreg = f;
            eb = mem_bus_m(mreg);
            e = mreg.data_ram_en & ~s[3];
            chk($sformatf("rnd%0d mem_bus", i), 160'(io.ex_to_mem_bus), 160'(eb));
            chk($sformatf("rnd%0d rf_bus", i), 160'(io.ex_to_rf_bus),
                160'({mreg.data_ram_en & mreg.sel_rf_res, mreg.rf_we, mreg.rf_waddr, eb[31:0]}));
            chk($sformatf("rnd%0d sram_en", i), 160'(io.data_sram_en), 160'(e));
            chk($sformatf("rnd%0d sram_wen", i), 160'(io.data_sram_wen), 160'((e & mreg.data_ram_wen) ? eb[42:39] : 4'h0));
            chk($sformatf("rnd%0d sram_addr", i), 160'(io.data_sram_addr), 160'(eb[31:0]));
            chk($sformatf("rnd%0d stallreq", i), 160'(io.stallreq_for_ex), 160'(0));
            if (|mreg.mem_op[2:0])
                chk($sformatf("rnd%0d wdata", i), 160'(io.data_sram_wdata), 160'(wdata_m(mreg.mem_op, mreg.rt_data)));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
